// File: rtl/led_fade_pkg.sv
// Shared defaults and helpers for the LED fade driver.
package led_fade_pkg;

  localparam int unsigned DEFAULT_NUM_LEDS = 10;
  localparam int unsigned DEFAULT_PWM_BITS = 8;
  localparam int unsigned DEFAULT_STEP_DIV = 1024;

  function automatic int unsigned max_level(input int unsigned bits);
    return (32'd1 << bits) - 32'd1;
  endfunction

endpackage

// File: rtl/led_fade_driver_if.sv
// Bundle of the LED fade driver's pattern/enable inputs and LED/busy outputs.
interface led_fade_driver_if #(
  parameter int unsigned NUM_LEDS = 10
);
  logic [NUM_LEDS-1:0] pattern_in;
  logic                enable;
  logic [NUM_LEDS-1:0] led_out;
  logic                busy;

  modport master (
    output pattern_in,
    output enable,
    input  led_out,
    input  busy
  );

  modport slave (
    input  pattern_in,
    input  enable,
    output led_out,
    output busy
  );
endinterface

// File: rtl/led_fade_channel.sv
// One LED channel: saturating level stepper, duty mapping and registered PWM compare.
// Define LED_FADE_GAMMA_EN for a squared (perceptual) duty curve; linear otherwise.
module led_fade_channel
  import led_fade_pkg::*;
#(
  parameter int unsigned PWM_BITS = DEFAULT_PWM_BITS
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                tick_i,
  input  logic                enable_i,
  input  logic                target_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
  output logic [PWM_BITS-1:0] level_o,
  output logic                led_o
);

  localparam logic [PWM_BITS-1:0] MAX_LVL = '1;

  logic [PWM_BITS-1:0] level_q, level_d;
  logic                led_q, led_d;
  logic [PWM_BITS-1:0] duty;

  always_comb begin
    level_d = level_q;
    if (tick_i) begin
      if (target_i && (level_q != MAX_LVL)) begin
        level_d = level_q + 1'b1;
      end else if (!target_i && (level_q != '0)) begin
        level_d = level_q - 1'b1;
      end
    end
  end

`ifdef LED_FADE_GAMMA_EN
  logic [2*PWM_BITS-1:0] level_sq;

  assign level_sq = {{PWM_BITS{1'b0}}, level_q} * {{PWM_BITS{1'b0}}, level_q};

  // The square of MAX falls just short of MAX after the shift, so full scale is pinned.
  always_comb begin
    duty = level_sq[2*PWM_BITS-1:PWM_BITS];
    if (level_q == MAX_LVL) begin
      duty = MAX_LVL;
    end
  end
`else
  assign duty = level_q;
`endif

  assign led_d = enable_i & ((duty == MAX_LVL) | (duty > pwm_cnt_i));

  always_ff @(posedge clk) begin
    if (reset) begin
      level_q <= '0;
      led_q   <= 1'b0;
    end else begin
      level_q <= level_d;
      led_q   <= led_d;
    end
  end

  assign level_o = level_q;
  assign led_o   = led_q;

endmodule

// File: rtl/led_fade_driver.sv
// Multi-channel LED fader: shared PWM counter, fade prescaler and busy flag.
// Optional LED_FADE_GAMMA_EN selects the squared duty curve inside each channel.
module led_fade_driver
  import led_fade_pkg::*;
#(
  parameter int unsigned NUM_LEDS = DEFAULT_NUM_LEDS,
  parameter int unsigned PWM_BITS = DEFAULT_PWM_BITS,
  parameter int unsigned STEP_DIV = DEFAULT_STEP_DIV
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NUM_LEDS-1:0] pattern_in,
  input  logic                enable,
  output logic [NUM_LEDS-1:0] led_out,
  output logic                busy
);

  localparam int unsigned         MAX_INT    = max_level(PWM_BITS);
  localparam logic [PWM_BITS-1:0] MAX_LVL    = MAX_INT[PWM_BITS-1:0];
  localparam int unsigned         PRESC_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam logic [PRESC_W-1:0]  PRESC_LAST = PRESC_W'(STEP_DIV - 1);

  logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic                busy_q, busy_d;
  logic                tick;
  logic [PWM_BITS-1:0] chan_level [NUM_LEDS];

  // A frozen prescaler parked on its last count must not keep stepping levels.
  assign tick = enable && (presc_q == PRESC_LAST);

  always_comb begin
    presc_d = presc_q;
    if (enable) begin
      presc_d = tick ? '0 : presc_q + 1'b1;
    end
  end

  assign pwm_cnt_d = pwm_cnt_q + 1'b1;

  always_comb begin
    busy_d = 1'b0;
    for (int unsigned i = 0; i < NUM_LEDS; i++) begin
      if (chan_level[i] != (pattern_in[i] ? MAX_LVL : '0)) begin
        busy_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pwm_cnt_q <= '0;
      presc_q   <= '0;
      busy_q    <= 1'b0;
    end else begin
      pwm_cnt_q <= pwm_cnt_d;
      presc_q   <= presc_d;
      busy_q    <= busy_d;
    end
  end

  for (genvar gi = 0; gi < NUM_LEDS; gi++) begin : g_chan
    led_fade_channel #(
      .PWM_BITS (PWM_BITS)
    ) u_chan (
      .clk       (clk),
      .reset     (reset),
      .tick_i    (tick),
      .enable_i  (enable),
      .target_i  (pattern_in[gi]),
      .pwm_cnt_i (pwm_cnt_q),
      .level_o   (chan_level[gi]),
      .led_o     (led_out[gi])
    );
  end

  assign busy = busy_q;

endmodule

// File: tb/tb_led_fade_driver.sv
// Directed self-checking bench for led_fade_driver (PWM_BITS=4, STEP_DIV=4, NUM_LEDS=10).
module tb_led_fade_driver;

  logic clk = 1'b0;
  logic reset;
  logic h_reset;
  int unsigned checks = 0;
  int unsigned errors = 0;
  int unsigned cyc = 0;
  int unsigned h_rel = 0;

  led_fade_driver_if #(.NUM_LEDS(10)) m_if ();
  led_fade_driver_if #(.NUM_LEDS(10)) h_if ();

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  led_fade_driver #(
    .NUM_LEDS (10),
    .PWM_BITS (4),
    .STEP_DIV (4)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .pattern_in (m_if.pattern_in),
    .enable     (m_if.enable),
    .led_out    (m_if.led_out),
    .busy       (m_if.busy)
  );

  // Slow-stepping instance: level sits at 8 for 256 clocks, long enough to measure duty.
  led_fade_driver #(
    .NUM_LEDS (10),
    .PWM_BITS (4),
    .STEP_DIV (256)
  ) u_hold (
    .clk        (clk),
    .reset      (h_reset),
    .pattern_in (h_if.pattern_in),
    .enable     (h_if.enable),
    .led_out    (h_if.led_out),
    .busy       (h_if.busy)
  );

  task automatic step(input int unsigned n);
    repeat (n) @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  initial begin
    int unsigned highs;
    int unsigned max_lvl;
    int unsigned exp_hold;

    reset = 1'b1;
    h_reset = 1'b1;
    m_if.pattern_in = 10'h3FF;
    m_if.enable = 1'b1;
    h_if.pattern_in = 10'h001;
    h_if.enable = 1'b1;
    step(3);
    check("rst_led", 32'(m_if.led_out), 32'h000);
    check("rst_busy", 32'(m_if.busy), 32'd0);
    check("rst_lvl0", 32'(dut.chan_level[0]), 32'd0);
    check("rst_lvl9", 32'(dut.chan_level[9]), 32'd0);

    // Ramp channel 0 up; P counts posedges since release.
    reset = 1'b0;
    h_reset = 1'b0;
    h_rel = cyc;
    m_if.pattern_in = 10'h001;
    step(4);
    check("ramp_lvl_p4", 32'(dut.chan_level[0]), 32'd1);
    step(13);
    check("ramp_led_p17", 32'(m_if.led_out), 32'h001);
    step(4);
`ifdef LED_FADE_GAMMA_EN
    check("ramp_led_p21", 32'(m_if.led_out), 32'h000);
`else
    check("ramp_led_p21", 32'(m_if.led_out), 32'h001);
`endif
    step(1);
    check("ramp_led_p22_eq", 32'(m_if.led_out), 32'h000);
    step(37);
    check("ramp_lvl_p59", 32'(dut.chan_level[0]), 32'd14);
    check("ramp_busy_p59", 32'(m_if.busy), 32'd1);
    step(1);
    check("ramp_lvl_p60", 32'(dut.chan_level[0]), 32'd15);
    check("ramp_busy_p60", 32'(m_if.busy), 32'd1);
    step(1);
    check("ramp_busy_p61", 32'(m_if.busy), 32'd0);
    check("ramp_led_p61", 32'(m_if.led_out), 32'h001);
    step(1);
    check("sat_lvl_max", 32'(dut.chan_level[0]), 32'd15);
    highs = 0;
    for (int k = 0; k < 16; k++) begin
      step(1);
      if (m_if.led_out === 10'h001) highs++;
    end
    check("max_always_on", highs, 32'd16);

    // Reversal mid-fade; P' counts posedges since this release.
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("pulse_rst_lvl", 32'(dut.chan_level[0]), 32'd0);
    step(17);
    check("rev_lvl_p17", 32'(dut.chan_level[0]), 32'd4);
    m_if.pattern_in = 10'h000;
    step(2);
    m_if.pattern_in = 10'h001;
    step(1);
    check("between_tick_ignored", 32'(dut.chan_level[0]), 32'd5);
    m_if.pattern_in = 10'h000;
    step(3);
    check("rev_lvl_p23", 32'(dut.chan_level[0]), 32'd5);
    step(1);
    check("rev_lvl_p24", 32'(dut.chan_level[0]), 32'd4);
    max_lvl = 0;
    for (int k = 0; k < 16; k++) begin
      step(1);
      if (32'(dut.chan_level[0]) > max_lvl) max_lvl = 32'(dut.chan_level[0]);
    end
    check("rev_no_glitch", max_lvl, 32'd4);
    check("rev_lvl_p40", 32'(dut.chan_level[0]), 32'd0);
    step(1);
    check("rev_busy_p41", 32'(m_if.busy), 32'd0);
    step(3);
    check("floor_lvl_p44", 32'(dut.chan_level[0]), 32'd0);

    // Enable drop at level 6 and resume.
    m_if.pattern_in = 10'h001;
    step(24);
    check("en_lvl_p68", 32'(dut.chan_level[0]), 32'd6);
    m_if.enable = 1'b0;
    step(1);
    check("dis_led_p69", 32'(m_if.led_out), 32'h000);
    check("dis_lvl_p69", 32'(dut.chan_level[0]), 32'd6);
    step(10);
    check("dis_lvl_p79", 32'(dut.chan_level[0]), 32'd6);
    check("dis_led_p79", 32'(m_if.led_out), 32'h000);
    check("dis_busy_p79", 32'(m_if.busy), 32'd1);
    m_if.enable = 1'b1;
    step(1);
    check("reen_led_p80", 32'(m_if.led_out), 32'h000);
    step(1);
    check("reen_led_p81", 32'(m_if.led_out), 32'h001);
    step(1);
    check("reen_lvl_p82", 32'(dut.chan_level[0]), 32'd6);
    step(1);
    check("reen_lvl_p83", 32'(dut.chan_level[0]), 32'd7);

    // Reset coincident with the next tick at P'=87.
    step(3);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check("rst_tick_lvl", 32'(dut.chan_level[0]), 32'd0);
    check("rst_tick_led", 32'(m_if.led_out), 32'h000);
    check("rst_tick_busy", 32'(m_if.busy), 32'd0);
    step(3);
    check("restart_lvl_p3", 32'(dut.chan_level[0]), 32'd0);
    check("restart_led_p3", 32'(m_if.led_out), 32'h000);
    step(1);
    check("restart_lvl_p4", 32'(dut.chan_level[0]), 32'd1);

    // Duty at a held level of 8 on the slow instance.
    while (cyc - h_rel < 2056) @(negedge clk);
    check("hold_lvl_start", 32'(u_hold.chan_level[0]), 32'd8);
    highs = 0;
    for (int k = 0; k < 16; k++) begin
      step(1);
      if (h_if.led_out[0] === 1'b1) highs++;
    end
`ifdef LED_FADE_GAMMA_EN
    exp_hold = 4;
`else
    exp_hold = 8;
`endif
    check("hold_duty_8", highs, exp_hold);
    check("hold_lvl_end", 32'(u_hold.chan_level[0]), 32'd8);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/led_fade_driver.md
LED_FADE_DRIVER -- requirements
Module: led_fade_driver

Interface
REQ-001 The block SHALL have parameter NUM_LEDS, default 10: number of LED channels, matching the LED PIO output width.
REQ-002 The block SHALL have parameter PWM_BITS, default 8: brightness level and PWM counter width; MAX = 2^PWM_BITS-1.
REQ-003 The block SHALL have parameter STEP_DIV, default 1024: clocks per fade step, legal range 1 and above.
REQ-004 The block SHALL have input clk, 1 bit: the single clock for the block.
REQ-005 The block SHALL have input reset, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have input pattern_in, NUM_LEDS bits: per-LED on/off target, driven directly by the LED PIO out_port in the clk domain.
REQ-007 The block SHALL have input enable, 1 bit: 1 runs fading and PWM output, 0 blanks the LEDs and freezes fading.
REQ-008 The block SHALL have output led_out, NUM_LEDS bits, registered: PWM drive to the board LEDs.
REQ-009 The block SHALL have output busy, 1 bit, registered: 1 while any channel level differs from its target.

Function
REQ-010 pwm_cnt (PWM_BITS) SHALL increment every clock and wrap from MAX to 0; it SHALL run regardless of enable.
REQ-011 The prescaler SHALL count 0..STEP_DIV-1 while enable=1 and hold while enable=0; tick SHALL be 1 for the single cycle in which the prescaler equals STEP_DIV-1.
REQ-012 On tick, each level[i] SHALL step once: +1 if pattern_in[i]=1 and level[i]<MAX; -1 if pattern_in[i]=0 and level[i]>0; otherwise unchanged (saturating, no wrap).
REQ-013 pattern_in SHALL be sampled only on tick; changes between ticks SHALL NOT alter levels.
REQ-014 A target reversal mid-fade SHALL reverse direction from the current level on the next tick, with no jump.
REQ-015 duty[i] SHALL equal level[i] (linear mapping, macro absent).
REQ-016 led_out[i] SHALL be registered as enable & ((duty[i]==MAX) | (duty[i] > pwm_cnt)): level 0 is always off, MAX is always on, one clock of latency.
REQ-017 When enable=0, led_out SHALL be all 0 from the next clock edge; levels SHALL hold, and resuming SHALL continue from the held levels.
REQ-018 busy SHALL be registered as OR over i of (level[i] != (pattern_in[i] ? MAX : 0)).

Reset
REQ-019 While reset=1 at a clk edge: pwm_cnt, prescaler, all levels, led_out and busy SHALL be 0.
REQ-020 Reset asserted mid-fade SHALL override any tick in the same cycle; the fade SHALL restart from 0 after release.

Configuration
REQ-021 With macro LED_FADE_GAMMA_EN defined, duty[i] SHALL be (level[i]*level[i]) >> PWM_BITS, using a 2*PWM_BITS-bit product, to give a perceptual curve; duty at MAX SHALL be forced to MAX.
REQ-022 Without LED_FADE_GAMMA_EN, the mapping SHALL be linear per REQ-015 and no multiplier SHALL be present.

Structure
REQ-023 Package led_fade_pkg SHALL hold the defaults for NUM_LEDS, PWM_BITS and STEP_DIV, plus the function computing MAX.
REQ-024 The per-LED level register, step logic, duty mapping and output compare SHALL live in sub-module led_fade_channel, instantiated NUM_LEDS times.
REQ-025 pwm_cnt, the prescaler and busy reduction SHALL be shared in the top level.

Verification (bench: PWM_BITS=4, STEP_DIV=4, NUM_LEDS=10)
REQ-026 Scenario: reset=1 for 3 clocks with pattern_in=0x3FF -> led_out=0x000, busy=0, all levels 0.
REQ-027 Scenario: pattern_in=0x001, enable=1 -> level[0] reaches 15 after 15 ticks (60 clocks); busy falls one clock later; led_out[0] is constant 1 thereafter.
REQ-028 Scenario: level[0] held at 8, linear -> led_out[0] high exactly 8 of every 16 clocks; with LED_FADE_GAMMA_EN -> high 4 of 16.
REQ-029 Scenario: pattern_in[0]=1 until level 5, then 0 -> next tick gives level 4, and levels descend to 0 with no glitch to 6.
REQ-030 Scenario: enable dropped at level 6 -> led_out=0 on the next edge and level stays 6; re-enable -> duty 6/16 and fading resumes from 6.
REQ-031 Scenario: reset pulsed for 1 clock at level 7, coincident with a tick -> level 0 and led_out 0 on the next edge.
